// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, parity
// selector constants and the default frame width.
package uart_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end: 2-flop synchronizer, oversample phase counter and a
// 3-sample majority vote centred on the middle of each bit period.
module uart_rx_sampler #(
  parameter int unsigned OVERSAMPLE = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_in,
  input  logic start_det_c,
  input  logic run,
  output logic rx_s,
  output logic bit_strobe_c,
  output logic bit_val_c,
  output logic bit_wrap_c
);

  localparam int unsigned EW = $clog2(OVERSAMPLE);
  localparam int unsigned M  = OVERSAMPLE / 2;

  logic          rx_meta;
  logic [EW-1:0] edge_cnt;
  logic          samp_a;
  logic          samp_b;

  // Synchronizer idles high so a reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      edge_cnt <= '0;
      samp_a   <= 1'b0;
      samp_b   <= 1'b0;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
      if (start_det_c) begin
        edge_cnt <= EW'(1);
      end else if (run) begin
        edge_cnt <= bit_wrap_c ? '0 : edge_cnt + EW'(1);
      end else begin
        edge_cnt <= '0;
      end
      if (edge_cnt == EW'(M - 1)) samp_a <= rx_s;
      if (edge_cnt == EW'(M))     samp_b <= rx_s;
    end
  end

  // The third sample is the live value, so the vote resolves at tick M+1.
  always_comb begin
    bit_wrap_c   = run && (edge_cnt == EW'(OVERSAMPLE - 1));
    bit_strobe_c = run && (edge_cnt == EW'(M + 1));
    bit_val_c    = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: frame FSM, LSB-first shift register, parity check and
// registered byte/strobe/error outputs.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned OVERSAMPLE = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  rx_state_e             state, state_nxt;
  logic [BW-1:0]         bit_cnt, bit_cnt_nxt;
  logic [DATA_WIDTH-1:0] shift_q, shift_nxt;
  logic [DATA_WIDTH-1:0] p_data_nxt;
  logic                  par_acc, par_acc_nxt;
  logic                  par_bad, par_bad_nxt;
  logic                  par_en_q, par_en_nxt;
  logic                  par_typ_q, par_typ_nxt;
  logic                  valid_nxt, par_err_nxt, stp_err_nxt;

  logic rx_s;
  logic start_det_c;
  logic bit_strobe_c;
  logic bit_val_c;
  logic bit_wrap_c;
  logic run;

  assign run = (state != ST_IDLE);

  uart_rx_sampler #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_sampler (
    .clk          (CLK),
    .rst_n        (RST),
    .rx_in        (RX_IN),
    .start_det_c  (start_det_c),
    .run          (run),
    .rx_s         (rx_s),
    .bit_strobe_c (bit_strobe_c),
    .bit_val_c    (bit_val_c),
    .bit_wrap_c   (bit_wrap_c)
  );

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shift_q    <= '0;
      par_acc    <= 1'b0;
      par_bad    <= 1'b0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shift_q    <= shift_nxt;
      par_acc    <= par_acc_nxt;
      par_bad    <= par_bad_nxt;
      par_en_q   <= par_en_nxt;
      par_typ_q  <= par_typ_nxt;
      P_DATA     <= p_data_nxt;
      DATA_VALID <= valid_nxt;
      PAR_ERR    <= par_err_nxt;
      STP_ERR    <= stp_err_nxt;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift_q;
    par_acc_nxt = par_acc;
    par_bad_nxt = par_bad;
    par_en_nxt  = par_en_q;
    par_typ_nxt = par_typ_q;
    p_data_nxt  = P_DATA;
    valid_nxt   = 1'b0;
    par_err_nxt = 1'b0;
    stp_err_nxt = 1'b0;
    start_det_c = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          state_nxt   = ST_START;
          start_det_c = 1'b1;
          par_en_nxt  = PAR_EN;
          par_typ_nxt = PAR_TYP;
          bit_cnt_nxt = '0;
          shift_nxt   = '0;
          par_acc_nxt = 1'b0;
          par_bad_nxt = 1'b0;
        end
      end

      ST_START: begin
        if (bit_strobe_c && bit_val_c) begin
          state_nxt = ST_IDLE;
        end else if (bit_wrap_c) begin
          state_nxt   = ST_DATA;
          bit_cnt_nxt = '0;
        end
      end

      ST_DATA: begin
        if (bit_strobe_c) begin
          shift_nxt[bit_cnt] = bit_val_c;
          par_acc_nxt        = par_acc ^ bit_val_c;
        end
        if (bit_wrap_c) begin
          if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
            state_nxt = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_nxt = bit_cnt + BW'(1);
          end
        end
      end

      ST_PARITY: begin
        if (bit_strobe_c && (bit_val_c != (par_acc ^ (par_typ_q == PAR_ODD)))) begin
          par_bad_nxt = 1'b1;
        end
        if (bit_wrap_c) state_nxt = ST_STOP;
      end

      ST_STOP: begin
        // Leave at mid-stop so the next start edge is caught with no gap.
        if (bit_strobe_c) begin
          state_nxt = ST_IDLE;
          if (!bit_val_c) begin
            stp_err_nxt = 1'b1;
          end else if (par_bad) begin
            par_err_nxt = 1'b1;
          end else begin
            valid_nxt  = 1'b1;
            p_data_nxt = shift_q;
          end
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
